binary_morph_3x3: RTL

BINARY_MORPH_3X3 -- requirements
Module: binary_morph_3x3

---
 rtl/binary_morph_3x3_pkg.sv | 27 ++
 rtl/binary_morph_3x3_if.sv | 35 +++
 rtl/binary_morph_3x3_pos_counter.sv | 80 ++++++++
 rtl/binary_morph_3x3.sv | 107 ++++++++++
 4 files changed

// File: rtl/binary_morph_3x3_pkg.sv
// Purpose : shared constants, types and the row/window reduction helper for
//           the 3x3 binary morphology block.
// Contents: MODE_ERODE / MODE_DILATE encodings, counter width, default frame
//           geometry, morph_rows_t (stage-1 row results), reduce3().
package morph_pkg;

    localparam logic        MODE_ERODE  = 1'b0;
    localparam logic        MODE_DILATE = 1'b1;

    localparam int unsigned CNT_W       = 12;
    localparam int unsigned DEF_HDISP   = 640;
    localparam int unsigned DEF_VDISP   = 480;

    // Per-row reductions held between the two pipeline stages.
    typedef struct packed {
        logic row1;
        logic row2;
        logic row3;
    } morph_rows_t;

    // AND of three for erosion, OR of three for dilation.
    function automatic logic reduce3(input logic mode, input logic a,
                                     input logic b, input logic c);
        return (mode == MODE_DILATE) ? (a | b | c) : (a & b & c);
    endfunction

endpackage

// File: rtl/binary_morph_3x3_if.sv
// Purpose : pixel-stream bundle of the 3x3 morphology block.
// Signals : mode, per_frame_{vsync,href,clken}, matrix_p11..p33 (towards the
//           block), post_frame_{vsync,href,clken}, post_img_bit (from it).
// Modports: master = stream source / sink side, slave = the morphology block.
interface binary_morph_3x3_if;

    logic mode;
    logic per_frame_vsync;
    logic per_frame_href;
    logic per_frame_clken;
    logic matrix_p11, matrix_p12, matrix_p13;
    logic matrix_p21, matrix_p22, matrix_p23;
    logic matrix_p31, matrix_p32, matrix_p33;
    logic post_frame_vsync;
    logic post_frame_href;
    logic post_frame_clken;
    logic post_img_bit;

    modport master (
        output mode, per_frame_vsync, per_frame_href, per_frame_clken,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33,
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
    );

    modport slave (
        input  mode, per_frame_vsync, per_frame_href, per_frame_clken,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33,
        output post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
    );

endinterface

// File: rtl/binary_morph_3x3_pos_counter.sv
// Purpose : column/row position of the incoming pixel and its border flag,
//           registered once so it lines up with the stage-1 row results.
//           Only built when MORPH_BORDER_ZERO_EN is defined.
// Ports   : clk, rst_n (sync, active-low), i_vsync, i_href, i_clken (stream
//           qualifiers at the stage-1 input), o_border_s1 (border flag of the
//           pixel currently held in stage 1).
`ifdef MORPH_BORDER_ZERO_EN
module morph_pos_counter
    import morph_pkg::*;
#(
    parameter int unsigned IMG_HDISP = DEF_HDISP,
    parameter int unsigned IMG_VDISP = DEF_VDISP
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vsync,
    input  logic i_href,
    input  logic i_clken,
    output logic o_border_s1
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_HDISP - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_VDISP - 1);

    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_row;
    logic             r_href_q;
    logic             r_vsync_q;
    logic             r_border_s1;

    logic w_href_fall;
    logic w_vsync_rise;
    logic w_col_last;
    logic w_row_last;
    logic w_border_in;

    assign w_href_fall  = r_href_q & ~i_href;
    assign w_vsync_rise = i_vsync & ~r_vsync_q;
    assign w_col_last   = (r_col == COL_LAST);
    assign w_row_last   = (r_row == ROW_LAST);
    // Counters hold the position of the pixel presented this cycle.
    assign w_border_in  = (r_col == '0) | w_col_last | (r_row == '0) | w_row_last;

    // Position counters; vsync clear beats the href-fall increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_href_q    <= 1'b0;
            r_vsync_q   <= 1'b0;
            r_border_s1 <= 1'b0;
        end else begin
            r_href_q  <= i_href;
            r_vsync_q <= i_vsync;

            if (w_href_fall) begin
                r_col <= '0;
            end else if (i_href && i_clken && !w_col_last) begin
                r_col <= r_col + CNT_W'(1);
            end

            if (w_vsync_rise) begin
                r_row <= '0;
            end else if (w_href_fall && !w_row_last) begin
                r_row <= r_row + CNT_W'(1);
            end

            // Same load/hold/clear rule as the stage-1 row registers.
            if (!i_href) begin
                r_border_s1 <= 1'b0;
            end else if (i_clken) begin
                r_border_s1 <= w_border_in;
            end
        end
    end

    assign o_border_s1 = r_border_s1;

endmodule
`endif

// File: rtl/binary_morph_3x3.sv
// Purpose : 3x3 binary erosion/dilation, two-stage pipeline (row reduce,
//           then column reduce), syncs delayed to match.
// Ports   : clk, rst_n (sync, active-low), bus (binary_morph_3x3_if.slave):
//           mode, per_frame_vsync/href/clken, matrix_p11..p33 in;
//           post_frame_vsync/href/clken, post_img_bit out.
// Config  : MORPH_BORDER_ZERO_EN forces the output to 0 on the first/last
//           column and row of the frame (adds morph_pos_counter).
module binary_morph_3x3
    import morph_pkg::*;
#(
    parameter int unsigned IMG_HDISP = DEF_HDISP,
    parameter int unsigned IMG_VDISP = DEF_VDISP
) (
    input  logic               clk,
    input  logic               rst_n,
    binary_morph_3x3_if.slave  bus
);

    if (IMG_HDISP < 1 || IMG_HDISP > 4095 || IMG_VDISP < 1 || IMG_VDISP > 4095) begin : g_bad_cfg
        $error("binary_morph_3x3: IMG_HDISP/IMG_VDISP must be in 1..4095");
    end

    logic        r_mode;
    logic        r_mode_s1;
    morph_rows_t r_rows;
    logic        r_bit;
    logic        r_vsync_d1, r_vsync_d2;
    logic        r_href_d1,  r_href_d2;
    logic        r_clken_d1, r_clken_d2;

    logic        w_vsync_rise;
    morph_rows_t w_rows;
    logic        w_window;
    logic        w_border_s1;

    assign w_vsync_rise = bus.per_frame_vsync & ~r_vsync_d1;

    assign w_rows.row1 = reduce3(r_mode, bus.matrix_p11, bus.matrix_p12, bus.matrix_p13);
    assign w_rows.row2 = reduce3(r_mode, bus.matrix_p21, bus.matrix_p22, bus.matrix_p23);
    assign w_rows.row3 = reduce3(r_mode, bus.matrix_p31, bus.matrix_p32, bus.matrix_p33);

    // Stage 2 uses the mode the stage-1 data was reduced with.
    assign w_window = reduce3(r_mode_s1, r_rows.row1, r_rows.row2, r_rows.row3);

`ifdef MORPH_BORDER_ZERO_EN
    morph_pos_counter #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP)
    ) u_pos (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_vsync     (bus.per_frame_vsync),
        .i_href      (bus.per_frame_href),
        .i_clken     (bus.per_frame_clken),
        .o_border_s1 (w_border_s1)
    );
`else
    assign w_border_s1 = 1'b0;
`endif

    // Sync delay line, frame-latched mode and both reduction stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode     <= MODE_ERODE;
            r_mode_s1  <= MODE_ERODE;
            r_rows     <= '0;
            r_bit      <= 1'b0;
            r_vsync_d1 <= 1'b0;
            r_vsync_d2 <= 1'b0;
            r_href_d1  <= 1'b0;
            r_href_d2  <= 1'b0;
            r_clken_d1 <= 1'b0;
            r_clken_d2 <= 1'b0;
        end else begin
            r_vsync_d1 <= bus.per_frame_vsync;
            r_vsync_d2 <= r_vsync_d1;
            r_href_d1  <= bus.per_frame_href;
            r_href_d2  <= r_href_d1;
            r_clken_d1 <= bus.per_frame_clken;
            r_clken_d2 <= r_clken_d1;

            // Mode only changes at frame start so a frame is never mixed.
            if (w_vsync_rise) begin
                r_mode <= bus.mode;
            end

            if (!bus.per_frame_href) begin
                r_rows <= '0;
            end else if (bus.per_frame_clken) begin
                r_rows    <= w_rows;
                r_mode_s1 <= r_mode;
            end

            if (!r_href_d1) begin
                r_bit <= 1'b0;
            end else if (r_clken_d1) begin
                r_bit <= w_window & ~w_border_s1;
            end
        end
    end

    assign bus.post_frame_vsync = r_vsync_d2;
    assign bus.post_frame_href  = r_href_d2;
    assign bus.post_frame_clken = r_clken_d2;
    assign bus.post_img_bit     = r_bit;

endmodule
